// File: rtl/banked_tdp_ram.sv
// ---------------------------------------------------------------------------
// banked_tdp_ram
//
// A RAM made of RAM_NUM independent banks. Each bank is a true dual-port RAM.
// The layer controllers drive port A and the PE array feeders drive port B.
//
// Each bank and each port has its own enable and write enable. Any enabled
// access also performs a read. Reads are read-first, so a write to an address
// returns the old word at that address. The read pipeline is configurable
// (RD_LAT = 1 or 2). Each port has a read-valid strobe, and each bank has a
// same-address collision strobe.
//
// Optional feature, controlled by the macro RAM_CLEAR_EN:
//   defined   - after reset, a sequencer writes zero to every address of
//               every bank. This takes 2**ADDRESS cycles. init_busy is high
//               while it runs, and all user requests are ignored.
//   undefined - there is no sequencer and init_busy is tied to 0. Memory
//               contents are undefined until they are written.
//
// Parameters:
//   RAM_NUM  number of banks
//   WIDTH    data bits per word
//   ADDRESS  address bits per bank (depth is 2**ADDRESS)
//   RD_LAT   read latency in cycles, 1 or 2
//
// Ports (per-bank signals are unpacked arrays [0:RAM_NUM-1]):
//   clk, rst           clock; synchronous active-high reset
//   ena/wea/addra/dina port A enable, write enable, address, write data
//   enb/web/addrb/dinb port B equivalents
//   douta/doutb        read data; holds when no new read completes
//   valida/validb      read-data-valid, RD_LAT cycles after an accepted request
//   collision          same-address access with at least one write, aligned
//                      with the valids
//   init_busy          clear sequence running (or rst held)
// ---------------------------------------------------------------------------
module banked_tdp_ram #(
    parameter int unsigned RAM_NUM = 16,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDRESS = 10,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena       [0:RAM_NUM-1],
    input  logic               wea       [0:RAM_NUM-1],
    input  logic [ADDRESS-1:0] addra     [0:RAM_NUM-1],
    input  logic [WIDTH-1:0]   dina      [0:RAM_NUM-1],
    input  logic               enb       [0:RAM_NUM-1],
    input  logic               web       [0:RAM_NUM-1],
    input  logic [ADDRESS-1:0] addrb     [0:RAM_NUM-1],
    input  logic [WIDTH-1:0]   dinb      [0:RAM_NUM-1],
    output logic [WIDTH-1:0]   douta     [0:RAM_NUM-1],
    output logic [WIDTH-1:0]   doutb     [0:RAM_NUM-1],
    output logic               valida    [0:RAM_NUM-1],
    output logic               validb    [0:RAM_NUM-1],
    output logic               collision [0:RAM_NUM-1],
    output logic               init_busy
);

    localparam int unsigned DEPTH = 1 << ADDRESS;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("banked_tdp_ram: RD_LAT must be 1 or 2");
        end
    endgenerate

    // blocked: user requests are dropped (reset or clearing)
    logic               blocked;
    logic               clr_we;
    logic [ADDRESS-1:0] clr_addr;

`ifdef RAM_CLEAR_EN
    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e             state_q, state_d;
    logic [ADDRESS-1:0] cnt_q, cnt_d;
    logic               clearing;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. The terminal count is detected before the counter wraps,
    // so the last address is still written on the edge that leaves StClear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + ADDRESS'(1);
                if (&cnt_q) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Outputs
    always_comb begin
        clearing  = (state_q == StClear);
        init_busy = rst || clearing;
        blocked   = rst || clearing;
        clr_we    = clearing && !rst;
        clr_addr  = cnt_q;
    end
`else
    always_comb begin
        init_busy = 1'b0;
        blocked   = rst;
        clr_we    = 1'b0;
        clr_addr  = '0;
    end
`endif

    for (genvar i = 0; i < RAM_NUM; i++) begin : g_bank
        logic [WIDTH-1:0]   mem [0:DEPTH-1];

        logic               acc_a, acc_b;
        logic               wr_a, wr_b;
        logic               we_a;
        logic [ADDRESS-1:0] wa;
        logic [WIDTH-1:0]   wd_a;
        logic               col_hit;

        logic [WIDTH-1:0]   rd_a_d, rd_a_q, rd_b_d, rd_b_q;
        logic               vld_a_d, vld_a_q, vld_b_d, vld_b_q;
        logic               col_d, col_q;

        always_comb begin
            acc_a   = ena[i] && !blocked;
            acc_b   = enb[i] && !blocked;
            wr_a    = acc_a && wea[i];
            // On a same-address double write port A wins, so B's write is dropped
            wr_b    = acc_b && web[i] && !(wr_a && (addra[i] == addrb[i]));
            col_hit = acc_a && acc_b && (addra[i] == addrb[i]) && (wea[i] || web[i]);

            // The clear sequencer borrows port A; user traffic is blocked then
            we_a    = clr_we || wr_a;
            wa      = clr_we ? clr_addr : addra[i];
            wd_a    = clr_we ? '0 : dina[i];

            // Read-first: sample the array before this edge's writes land
            rd_a_d  = acc_a ? mem[addra[i]] : rd_a_q;
            rd_b_d  = acc_b ? mem[addrb[i]] : rd_b_q;
            vld_a_d = acc_a;
            vld_b_d = acc_b;
            col_d   = col_hit;
        end

        // Array storage, not reset
        always_ff @(posedge clk) begin
            if (we_a) begin
                mem[wa] <= wd_a;
            end
            if (wr_b) begin
                mem[addrb[i]] <= dinb[i];
            end
        end

        // First read stage
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_a_q  <= '0;
                rd_b_q  <= '0;
                vld_a_q <= 1'b0;
                vld_b_q <= 1'b0;
                col_q   <= 1'b0;
            end else begin
                rd_a_q  <= rd_a_d;
                rd_b_q  <= rd_b_d;
                vld_a_q <= vld_a_d;
                vld_b_q <= vld_b_d;
                col_q   <= col_d;
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] out_a_d, out_a_q, out_b_d, out_b_q;
            logic             ova_d, ova_q, ovb_d, ovb_q;
            logic             ocol_d, ocol_q;

            always_comb begin
                out_a_d = vld_a_q ? rd_a_q : out_a_q;
                out_b_d = vld_b_q ? rd_b_q : out_b_q;
                ova_d   = vld_a_q;
                ovb_d   = vld_b_q;
                ocol_d  = col_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_a_q <= '0;
                    out_b_q <= '0;
                    ova_q   <= 1'b0;
                    ovb_q   <= 1'b0;
                    ocol_q  <= 1'b0;
                end else begin
                    out_a_q <= out_a_d;
                    out_b_q <= out_b_d;
                    ova_q   <= ova_d;
                    ovb_q   <= ovb_d;
                    ocol_q  <= ocol_d;
                end
            end

            assign douta[i]     = out_a_q;
            assign doutb[i]     = out_b_q;
            assign valida[i]    = ova_q;
            assign validb[i]    = ovb_q;
            assign collision[i] = ocol_q;
        end else begin : g_lat1
            assign douta[i]     = rd_a_q;
            assign doutb[i]     = rd_b_q;
            assign valida[i]    = vld_a_q;
            assign validb[i]    = vld_b_q;
            assign collision[i] = col_q;
        end
    end

endmodule

// File: tb/tb_banked_tdp_ram.sv
// ---------------------------------------------------------------------------
// tb_banked_tdp_ram
//
// Two instances of banked_tdp_ram, one with RD_LAT=1 and one with RD_LAT=2,
// are driven with identical stimulus. A behavioural model tracks three
// things: the memory contents, the clear sequencer (when RAM_CLEAR_EN is
// defined), and the expected outputs of each latency after every edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_banked_tdp_ram;

    localparam int NB    = 8;
    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ena   [0:NB-1];
    logic          wea   [0:NB-1];
    logic [AW-1:0] addra [0:NB-1];
    logic [W-1:0]  dina  [0:NB-1];
    logic          enb   [0:NB-1];
    logic          web   [0:NB-1];
    logic [AW-1:0] addrb [0:NB-1];
    logic [W-1:0]  dinb  [0:NB-1];

    logic [W-1:0]  douta1 [0:NB-1];
    logic [W-1:0]  doutb1 [0:NB-1];
    logic          valida1 [0:NB-1];
    logic          validb1 [0:NB-1];
    logic          col1 [0:NB-1];
    logic          busy1;
    logic [W-1:0]  douta2 [0:NB-1];
    logic [W-1:0]  doutb2 [0:NB-1];
    logic          valida2 [0:NB-1];
    logic          validb2 [0:NB-1];
    logic          col2 [0:NB-1];
    logic          busy2;

    banked_tdp_ram #(.RAM_NUM(NB), .WIDTH(W), .ADDRESS(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .douta(douta1), .doutb(doutb1), .valida(valida1), .validb(validb1),
        .collision(col1), .init_busy(busy1)
    );

    banked_tdp_ram #(.RAM_NUM(NB), .WIDTH(W), .ADDRESS(AW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .douta(douta2), .doutb(doutb2), .valida(valida2), .validb(validb2),
        .collision(col2), .init_busy(busy2)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] da;
        logic [W-1:0] db;
        logic         ka;   // da is a known value
        logic         kb;
        logic         va;
        logic         vb;
        logic         c;
    } exp_t;

    logic [W-1:0] m_mem   [NB][DEPTH];
    bit           m_known [NB][DEPTH];
    bit           m_busy = 1'b0;
    int           m_cnt  = 0;
    exp_t         e1 [NB];  // expected outputs, latency 1
    exp_t         e2 [NB];  // expected outputs, latency 2

    function automatic logic model_busy();
`ifdef RAM_CLEAR_EN
        return rst || m_busy;
`else
        return 1'b0;
`endif
    endfunction

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic step();
        logic acc_a [NB];
        logic acc_b [NB];
        for (int i = 0; i < NB; i++) begin
            acc_a[i] = ena[i] && !rst && !m_busy;
            acc_b[i] = enb[i] && !rst && !m_busy;
            e2[i]    = e1[i];
            e1[i].va = acc_a[i];
            e1[i].vb = acc_b[i];
            e1[i].c  = acc_a[i] && acc_b[i] && (addra[i] == addrb[i]) && (wea[i] || web[i]);
            if (acc_a[i]) begin
                e1[i].da = m_mem[i][addra[i]];
                e1[i].ka = m_known[i][addra[i]];
            end
            if (acc_b[i]) begin
                e1[i].db = m_mem[i][addrb[i]];
                e1[i].kb = m_known[i][addrb[i]];
            end
            if (rst) begin
                e1[i]    = '0;
                e1[i].ka = 1'b1;
                e1[i].kb = 1'b1;
                e2[i]    = e1[i];
            end
        end
        if (rst) begin
`ifdef RAM_CLEAR_EN
            m_busy = 1'b1;
            m_cnt  = 0;
`endif
        end else if (m_busy) begin
            for (int i = 0; i < NB; i++) begin
                m_mem[i][m_cnt]   = '0;
                m_known[i][m_cnt] = 1'b1;
            end
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            m_cnt++;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (acc_b[i] && web[i]) begin
                    m_mem[i][addrb[i]]   = dinb[i];
                    m_known[i][addrb[i]] = 1'b1;
                end
                // A applied last: it wins a same-address double write
                if (acc_a[i] && wea[i]) begin
                    m_mem[i][addra[i]]   = dina[i];
                    m_known[i][addra[i]] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < NB; i++) begin
            ena[i] = 1'b0; wea[i] = 1'b0; addra[i] = '0; dina[i] = '0;
            enb[i] = 1'b0; web[i] = 1'b0; addrb[i] = '0; dinb[i] = '0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < NB; i++) begin
            checks++;
            if ({douta1[i], doutb1[i], douta2[i], doutb2[i], valida1[i], validb1[i],
                 col1[i], valida2[i], validb2[i], col2[i]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs bank %0d got %h/%h/%h/%h v=%b%b%b%b%b%b exp all 0",
                         i, douta1[i], doutb1[i], douta2[i], doutb2[i], valida1[i],
                         validb1[i], col1[i], valida2[i], validb2[i], col2[i]);
            end
        end
        checks++;
        if (busy1 !== model_busy() || busy2 !== model_busy()) begin
            failures++;
            $display("FAIL reset_busy got %b/%b exp %b", busy1, busy2, model_busy());
        end
    endtask

`ifdef RAM_CLEAR_EN
    task automatic test_clear();
        int n;
        int b;
        int a;
        rst = 1'b0;
        #1;
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL clear_busy_cycles got %0d exp %0d", n, DEPTH);
        end
        for (int k = 0; k < 8; k++) begin
            b = $urandom_range(0, NB - 1);
            a = $urandom_range(0, DEPTH - 1);
            idle();
            ena[b]   = 1'b1;
            addra[b] = AW'(a);
            step();
            idle();
            checks++;
            if (douta1[b] !== 16'h0000 || valida1[b] !== 1'b1) begin
                failures++;
                $display("FAIL clear_read bank %0d addr %0d got %h v=%b exp 0000 v=1",
                         b, a, douta1[b], valida1[b]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < NB; i++) begin
                ena[i] = 1'b1; wea[i] = 1'b1; addra[i] = AW'($urandom); dina[i] = 16'hFFFF;
                enb[i] = 1'b1; web[i] = 1'b0; addrb[i] = AW'($urandom);
            end
            step();
            checks++;
            if (busy1 !== 1'b1) begin
                failures++;
                $display("FAIL midclr_busy cycle %0d got %b exp 1", k, busy1);
            end
        end
        // the clear counter is now 9
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            for (int i = 0; i < NB; i++) begin
                ena[i] = 1'b1; wea[i] = 1'b1; addra[i] = AW'($urandom); dina[i] = 16'hFFFF;
                enb[i] = 1'b1; web[i] = 1'b1; addrb[i] = AW'($urandom); dinb[i] = 16'hFFFF;
            end
            step();
            n++;
            for (int i = 0; i < NB; i++) begin
                checks++;
                if ({valida1[i], validb1[i], col1[i], valida2[i], validb2[i], col2[i]} !== '0)
                begin
                    failures++;
                    $display("FAIL midclr_no_valid bank %0d got %b%b%b%b%b%b exp 000000", i,
                             valida1[i], validb1[i], col1[i], valida2[i], validb2[i], col2[i]);
                end
            end
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL midclr_busy_cycles got %0d exp %0d", n, DEPTH);
        end
        // Locations written by earlier tests must be zero again
        idle();
        ena[3] = 1'b1; addra[3] = 4'd5;
        enb[7] = 1'b1; addrb[7] = 4'd9;
        ena[2] = 1'b1; addra[2] = 4'd3;
        step();
        idle();
        checks++;
        if (douta1[3] !== 16'h0 || doutb1[7] !== 16'h0 || douta1[2] !== 16'h0) begin
            failures++;
            $display("FAIL midclr_cleared got %h %h %h exp 0000 0000 0000",
                     douta1[3], doutb1[7], douta1[2]);
        end
        step();
    endtask
`else
    task automatic test_no_clear();
        rst      = 1'b0;
        ena[1]   = 1'b1;
        wea[1]   = 1'b1;
        addra[1] = 4'd2;
        dina[1]  = 16'h1234;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL noclr_busy_release got %b exp 0", busy1);
        end
        step();
        idle();
        enb[1]   = 1'b1;
        addrb[1] = 4'd2;
        step();
        idle();
        checks++;
        if (doutb1[1] !== 16'h1234 || validb1[1] !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL noclr_read_lat1 got %h v=%b busy=%b exp 1234 v=1 busy=0",
                     doutb1[1], validb1[1], busy1);
        end
        step();
        checks++;
        if (doutb2[1] !== 16'h1234 || validb2[1] !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL noclr_read_lat2 got %h v=%b busy=%b exp 1234 v=1 busy=0",
                     doutb2[1], validb2[1], busy2);
        end
    endtask
`endif

    task automatic test_write_read();
        idle();
        ena[3] = 1'b1; wea[3] = 1'b1; addra[3] = 4'd5; dina[3] = 16'hBEEF;
        step();
        idle();
        enb[3] = 1'b1; addrb[3] = 4'd5;
        step();
        idle();
        checks++;
        if (doutb1[3] !== 16'hBEEF || validb1[3] !== 1'b1 || validb2[3] !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_lat1 got %h v1=%b v2=%b exp BEEF v1=1 v2=0",
                     doutb1[3], validb1[3], validb2[3]);
        end
        step();
        checks++;
        if (doutb2[3] !== 16'hBEEF || validb2[3] !== 1'b1 || validb1[3] !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_lat2 got %h v2=%b v1=%b exp BEEF v2=1 v1=0",
                     doutb2[3], validb2[3], validb1[3]);
        end
    endtask

    task automatic test_dual_write();
        idle();
        ena[7] = 1'b1; wea[7] = 1'b1; addra[7] = 4'd9; dina[7] = 16'h1111;
        enb[7] = 1'b1; web[7] = 1'b1; addrb[7] = 4'd9; dinb[7] = 16'h2222;
        step();
        idle();
        checks++;
        if (col1[7] !== 1'b1 || col2[7] !== 1'b0) begin
            failures++;
            $display("FAIL dual_col_edge1 got c1=%b c2=%b exp c1=1 c2=0", col1[7], col2[7]);
        end
        step();
        checks++;
        if (col1[7] !== 1'b0 || col2[7] !== 1'b1) begin
            failures++;
            $display("FAIL dual_col_edge2 got c1=%b c2=%b exp c1=0 c2=1", col1[7], col2[7]);
        end
        ena[7] = 1'b1; addra[7] = 4'd9;
        step();
        idle();
        checks++;
        if (col2[7] !== 1'b0 || douta1[7] !== 16'h1111 || valida1[7] !== 1'b1) begin
            failures++;
            $display("FAIL dual_readback got c2=%b d=%h v=%b exp c2=0 d=1111 v=1",
                     col2[7], douta1[7], valida1[7]);
        end
        step();
    endtask

    task automatic test_read_first();
        idle();
        ena[2] = 1'b1; wea[2] = 1'b1; addra[2] = 4'd3; dina[2] = 16'h00AA;
        step();
        ena[2] = 1'b1; wea[2] = 1'b1; addra[2] = 4'd3; dina[2] = 16'h00BB;
        enb[2] = 1'b1; web[2] = 1'b0; addrb[2] = 4'd3;
        step();
        idle();
        checks++;
        if (doutb1[2] !== 16'h00AA || col1[2] !== 1'b1) begin
            failures++;
            $display("FAIL rdfirst_lat1 got %h c=%b exp 00AA c=1", doutb1[2], col1[2]);
        end
        enb[2] = 1'b1; addrb[2] = 4'd3;
        step();
        idle();
        checks++;
        if (doutb2[2] !== 16'h00AA || col2[2] !== 1'b1) begin
            failures++;
            $display("FAIL rdfirst_lat2 got %h c=%b exp 00AA c=1", doutb2[2], col2[2]);
        end
        checks++;
        if (doutb1[2] !== 16'h00BB || col1[2] !== 1'b0) begin
            failures++;
            $display("FAIL rdfirst_next got %h c=%b exp 00BB c=0", doutb1[2], col1[2]);
        end
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NB; i++) begin
                ena[i]   = $urandom_range(0, 2) != 0;
                wea[i]   = $urandom_range(0, 1) != 0;
                addra[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                dina[i]  = W'($urandom);
                enb[i]   = $urandom_range(0, 2) != 0;
                web[i]   = $urandom_range(0, 1) != 0;
                addrb[i] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                dinb[i]  = W'($urandom);
            end
            step();
            checks++;
            if (busy1 !== model_busy() || busy2 !== model_busy()) begin
                failures++;
                $display("FAIL rand_busy cyc %0d got %b/%b exp %b", cyc, busy1, busy2,
                         model_busy());
            end
            for (int i = 0; i < NB; i++) begin
                checks++;
                if ({valida1[i], validb1[i], col1[i], valida2[i], validb2[i], col2[i]} !==
                    {e1[i].va, e1[i].vb, e1[i].c, e2[i].va, e2[i].vb, e2[i].c}) begin
                    failures++;
                    $display("FAIL rand_strobes cyc %0d bank %0d got %b%b%b%b%b%b exp %b%b%b%b%b%b",
                             cyc, i, valida1[i], validb1[i], col1[i], valida2[i], validb2[i],
                             col2[i], e1[i].va, e1[i].vb, e1[i].c, e2[i].va, e2[i].vb, e2[i].c);
                end
                if (e1[i].ka) begin
                    checks++;
                    if (douta1[i] !== e1[i].da) begin
                        failures++;
                        $display("FAIL rand_douta1 cyc %0d bank %0d got %h exp %h",
                                 cyc, i, douta1[i], e1[i].da);
                    end
                end
                if (e1[i].kb) begin
                    checks++;
                    if (doutb1[i] !== e1[i].db) begin
                        failures++;
                        $display("FAIL rand_doutb1 cyc %0d bank %0d got %h exp %h",
                                 cyc, i, doutb1[i], e1[i].db);
                    end
                end
                if (e2[i].ka) begin
                    checks++;
                    if (douta2[i] !== e2[i].da) begin
                        failures++;
                        $display("FAIL rand_douta2 cyc %0d bank %0d got %h exp %h",
                                 cyc, i, douta2[i], e2[i].da);
                    end
                end
                if (e2[i].kb) begin
                    checks++;
                    if (doutb2[i] !== e2[i].db) begin
                        failures++;
                        $display("FAIL rand_doutb2 cyc %0d bank %0d got %h exp %h",
                                 cyc, i, doutb2[i], e2[i].db);
                    end
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < NB; i++) begin
            e1[i] = '0;
            e2[i] = '0;
        end
        rst = 1'b1;
        idle();
        test_reset();
`ifdef RAM_CLEAR_EN
        test_clear();
`else
        test_no_clear();
`endif
        test_write_read();
        test_dual_write();
        test_read_first();
`ifdef RAM_CLEAR_EN
        test_reset_mid_clear();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/banked_tdp_ram.md
# banked_tdp_ram

Parametrised multi-bank true-dual-port RAM: the next-generation activation/weight store for the accelerator datapath. Each bank has independent per-port enables and write enables, a configurable read pipeline, read-valid strobes, per-bank address-collision detection and an optional post-reset memory-clear sequencer. It sits between the layer controllers, which drive port A, and the PE array feeders, which drive port B.

## Interface
Parameters:
- RAM_NUM, 16, number of banks
- WIDTH, 16, data bits per word
- ADDRESS, 10, address bits per bank (depth 2**ADDRESS)
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (other values: elaboration error)

Ports (unpacked arrays indexed [0:RAM_NUM-1]):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  RAM_NUM  per-bank port A enable
- wea  in  RAM_NUM  per-bank port A write enable (qualified by ena)
- addra  in  ADDRESS x RAM_NUM  port A address per bank
- dina  in  WIDTH x RAM_NUM  port A write data per bank
- enb, web, addrb, dinb: port B equivalents of the above
- douta, doutb  out  WIDTH x RAM_NUM  read data per bank
- valida, validb  out  RAM_NUM  per-bank read-data-valid strobe
- collision  out  RAM_NUM  per-bank collision strobe
- init_busy  out  1  clear sequence in progress; all user requests ignored

## Operation
- Access is read-first: a port that reads and writes the same address in one cycle returns the old word.
- Any enabled access (read or write) produces a read. valida[i] and validb[i] pulse exactly RD_LAT cycles after ena[i] or enb[i] is sampled high.
- douta and doutb hold their last value when no new read completes.
- Collision on bank i: ena[i] and enb[i] are both high, addra[i]==addrb[i], and (wea[i] or web[i]) is high.
  - If both ports write, port A's data is stored.
  - If one port writes, the reading port returns the old word.
  - collision[i] pulses aligned with the resulting valid strobes, i.e. RD_LAT cycles after the request.
- Clear FSM (see Configuration), states CLEAR and READY:
  - rst sets the state to CLEAR and the counter to 0.
  - In CLEAR, every cycle writes 0 to address counter in all banks, then increments the counter.
  - When the counter reaches 2**ADDRESS-1, that last address is written and the state moves to READY.
  - init_busy=1 in CLEAR. User enables are ignored: no writes, no valids, no collisions.
- rst asserted at any time, including mid-clear, restarts the clear from address 0. Memory contents are not otherwise reset.

## Timing
- Reset values: douta=0, doutb=0, valida=0, validb=0, collision=0. The RD_LAT=2 pipeline stages also reset to 0.
- init_busy is 1 during rst and for 2**ADDRESS cycles after rst deasserts. It goes to 0 on the edge that writes the last address.
- A write is visible to a read on either port issued in the next cycle or later.
- RD_LAT=1: data registered from the array. RD_LAT=2: one extra output register.
- Full throughput on both ports: one request per port per bank per cycle, no back-pressure.
- Address wrap-around is natural: the counter is ADDRESS bits wide, and the terminal count is detected before it wraps.

## Configuration
- RAM_CLEAR_EN defined:
  - The clear FSM and counter are compiled in, with behaviour as above.
  - After clear, every location reads 0.
- RAM_CLEAR_EN undefined:
  - No FSM; init_busy is tied to 0.
  - The block accepts requests on the first cycle after rst deasserts.
  - Memory contents are undefined until written.
  - All output and pipeline reset behaviour is unchanged.

## Test plan
- Clear (macro on, ADDRESS=4):
  - Stimulus: release rst, poll.
  - Response: init_busy is high for 16 cycles. A read of any bank/address afterwards returns 0x0000 with valida one cycle later (RD_LAT=1).
- Write/read latency:
  - Stimulus: port A writes 0xBEEF to bank 3, addr 5, then port B reads it the next cycle.
  - Response: doutb[3]=0xBEEF and validb[3]=1 exactly RD_LAT cycles after the read, for both RD_LAT=1 and RD_LAT=2.
- Dual-write collision:
  - Stimulus: bank 7, addr 9, A writes 0x1111, B writes 0x2222 in the same cycle.
  - Response: collision[7] pulses once, RD_LAT later. A subsequent read returns 0x1111.
- Read-first collision:
  - Stimulus: location holds 0x00AA. A writes 0x00BB while B reads the same address.
  - Response: doutb=0x00AA with collision pulse. The next read returns 0x00BB.
- Reset mid-clear:
  - Stimulus: assert rst at clear counter 9, release it.
  - Response: init_busy stays high for a full 2**ADDRESS cycles again. Requests issued during CLEAR produce no valids and no writes.
- Macro off:
  - Stimulus: write then read on the first post-reset cycle.
  - Response: init_busy=0 throughout, and data returns with correct latency.
